// File: rtl/sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Parks the first half-frame in an external delay buffer, then emits sums and feeds differences back.
module sdf_butterfly #(
    parameter int WIDTH      = 16,
    parameter int DELAY      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int SCALE      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_en,
    input  logic [WIDTH-1:0]     in_re,
    input  logic [WIDTH-1:0]     in_im,
    output logic                 db_wr_en,
    output logic [2*WIDTH-1:0]   db_wr_data,
    input  logic [2*WIDTH-1:0]   db_rd_data,
    output logic                 out_en,
    output logic [WIDTH-1:0]     out_re,
    output logic [WIDTH-1:0]     out_im
);

    localparam logic [ADDR_WIDTH:0] CNT_LAST = {(ADDR_WIDTH+1){1'b1}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Scaled results drop the LSB, which is an arithmetic shift toward -inf.
    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH:0] v);
        if (SCALE != 0) begin
            fit = v[WIDTH:1];
        end else begin
            fit = v[WIDTH-1:0];
        end
    endfunction

    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                primed_q, primed_d;
    logic                out_en_q, out_en_d;
    logic [WIDTH-1:0]    out_re_q, out_re_d;
    logic [WIDTH-1:0]    out_im_q, out_im_d;

    logic                bf_s;
    logic [WIDTH-1:0]    a_re_s, a_im_s;
    logic [WIDTH:0]      sum_re_s, sum_im_s, dif_re_s, dif_im_s;

    assign bf_s     = cnt_q[ADDR_WIDTH];
    assign a_re_s   = db_rd_data[2*WIDTH-1:WIDTH];
    assign a_im_s   = db_rd_data[WIDTH-1:0];
    assign sum_re_s = {a_re_s[WIDTH-1], a_re_s} + {in_re[WIDTH-1], in_re};
    assign sum_im_s = {a_im_s[WIDTH-1], a_im_s} + {in_im[WIDTH-1], in_im};
    assign dif_re_s = {a_re_s[WIDTH-1], a_re_s} - {in_re[WIDTH-1], in_re};
    assign dif_im_s = {a_im_s[WIDTH-1], a_im_s} - {in_im[WIDTH-1], in_im};

    // Buffer write path: raw input while filling, differences while butterflying.
    always_comb begin
        db_wr_en = in_en;
        if (bf_s) begin
            db_wr_data = {fit(dif_re_s), fit(dif_im_s)};
        end else begin
            db_wr_data = {in_re, in_im};
        end
    end

    // Next-state for the beat counter, primed flag and output register.
    always_comb begin
        cnt_d    = cnt_q;
        primed_d = primed_q;
        out_en_d = 1'b0;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (in_en) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
                primed_d = 1'b1;
            end else begin
                primed_d = primed_q;
            end
            if (bf_s) begin
                out_en_d = 1'b1;
                out_re_d = fit(sum_re_s);
                out_im_d = fit(sum_im_s);
            end else begin
                // Drained differences are only genuine once a full frame has gone through.
                out_en_d = primed_q;
                out_re_d = a_re_s;
                out_im_d = a_im_s;
            end
        end else begin
            out_en_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= {(ADDR_WIDTH+1){1'b0}};
            primed_q <= 1'b0;
            out_en_q <= 1'b0;
            out_re_q <= {WIDTH{1'b0}};
            out_im_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            out_en_q <= out_en_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign out_en = out_en_q;
    assign out_re = out_re_q;
    assign out_im = out_im_q;

endmodule

// File: tb/tb_sdf_butterfly.sv
// Bench for sdf_butterfly: SCALE=0 and SCALE=1 instances share one stimulus stream,
// each closed through its own delay-buffer model, checked against a frame-level scoreboard.
module tb_sdf_butterfly;

    localparam int W = 16;
    localparam int D = 8;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_en = 1'b0;
    logic [W-1:0]  in_re = '0;
    logic [W-1:0]  in_im = '0;

    logic          wr_en0, wr_en1, oen0, oen1;
    logic [2*W-1:0] wr0, wr1, rd0, rd1;
    logic [W-1:0]  ore0, oim0, ore1, oim1;

    logic [2*W-1:0] dbuf0 [D];
    logic [2*W-1:0] dbuf1 [D];
    logic           acc_q = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int n_out0 = 0;
    int n_out1 = 0;

    logic [2*W-1:0] q0 [$];
    logic [2*W-1:0] q1 [$];
    logic [W-1:0]   cap0 [$];
    logic [W-1:0]   cap1 [$];

    logic [W-1:0] fx_re [2*D];
    logic [W-1:0] fx_im [2*D];
    int           mcnt = 0;

    always #5 clock = ~clock;

    sdf_butterfly #(.WIDTH(W), .DELAY(D), .ADDR_WIDTH(AW), .SCALE(0)) u0 (
        .clock(clock), .reset(reset), .in_en(in_en), .in_re(in_re), .in_im(in_im),
        .db_wr_en(wr_en0), .db_wr_data(wr0), .db_rd_data(rd0),
        .out_en(oen0), .out_re(ore0), .out_im(oim0));

    sdf_butterfly #(.WIDTH(W), .DELAY(D), .ADDR_WIDTH(AW), .SCALE(1)) u1 (
        .clock(clock), .reset(reset), .in_en(in_en), .in_re(in_re), .in_im(in_im),
        .db_wr_en(wr_en1), .db_wr_data(wr1), .db_rd_data(rd1),
        .out_en(oen1), .out_re(ore1), .out_im(oim1));

    assign rd0 = dbuf0[D-1];
    assign rd1 = dbuf1[D-1];

    // Delay-buffer models: shift one place per write strobe.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                dbuf0[i] <= '0;
                dbuf1[i] <= '0;
            end
        end else begin
            if (wr_en0) begin
                dbuf0[0] <= wr0;
                for (int i = 1; i < D; i++) dbuf0[i] <= dbuf0[i-1];
            end
            if (wr_en1) begin
                dbuf1[0] <= wr1;
                for (int i = 1; i < D; i++) dbuf1[i] <= dbuf1[i-1];
            end
        end
        acc_q <= in_en && !reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] bfly(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sub, input bit scale);
        logic signed [W:0] v;
        v = sub ? ($signed({a[W-1], a}) - $signed({b[W-1], b}))
                : ($signed({a[W-1], a}) + $signed({b[W-1], b}));
        if (scale) v = v >>> 1;
        return v[W-1:0];
    endfunction

    // Output monitor: every valid output must follow an accepted beat and match the scoreboard.
    always @(negedge clock) begin
        if (oen0) begin
            check_eq("u0_en_after_beat", {31'd0, acc_q}, 32'd1);
            n_out0++;
            cap0.push_back(ore0);
            if (q0.size() == 0) begin
                check_eq("u0_unexpected_out", {31'd0, oen0}, 32'd0);
            end else begin
                check_eq("u0_data", {ore0, oim0}, q0.pop_front());
            end
        end
        if (oen1) begin
            check_eq("u1_en_after_beat", {31'd0, acc_q}, 32'd1);
            n_out1++;
            cap1.push_back(ore1);
            if (q1.size() == 0) begin
                check_eq("u1_unexpected_out", {31'd0, oen1}, 32'd0);
            end else begin
                check_eq("u1_data", {ore1, oim1}, q1.pop_front());
            end
        end
    end

    task automatic model_step(input logic [W-1:0] re, input logic [W-1:0] im);
        int k;
        fx_re[mcnt] = re;
        fx_im[mcnt] = im;
        if (mcnt >= D) begin
            k = mcnt - D;
            q0.push_back({bfly(fx_re[k], re, 1'b0, 1'b0), bfly(fx_im[k], im, 1'b0, 1'b0)});
            q1.push_back({bfly(fx_re[k], re, 1'b0, 1'b1), bfly(fx_im[k], im, 1'b0, 1'b1)});
        end
        if (mcnt == 2*D-1) begin
            for (int j = 0; j < D; j++) begin
                q0.push_back({bfly(fx_re[j], fx_re[j+D], 1'b1, 1'b0),
                              bfly(fx_im[j], fx_im[j+D], 1'b1, 1'b0)});
                q1.push_back({bfly(fx_re[j], fx_re[j+D], 1'b1, 1'b1),
                              bfly(fx_im[j], fx_im[j+D], 1'b1, 1'b1)});
            end
        end
        mcnt = (mcnt + 1) % (2*D);
    endtask

    task automatic drive(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
        @(posedge clock);
        #1;
        in_en = en;
        in_re = re;
        in_im = im;
        if (en) model_step(re, im);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        in_en = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mcnt = 0;
        q0.delete();
        q1.delete();
        cap0.delete();
        cap1.delete();
        @(negedge clock);
        check_eq("rst_u0_state", {oen0, 15'd0, ore0 | oim0}, 32'd0);
        check_eq("rst_u1_state", {oen1, 15'd0, ore1 | oim1}, 32'd0);
    endtask

    task automatic basic_stream(input bit gapped);
        for (int i = 1; i <= 2*D; i++) begin
            drive(1'b1, W'(i), '0);
            if (gapped) idle($urandom_range(0, 2));
        end
        for (int i = 0; i < D; i++) begin
            drive(1'b1, '0, '0);
            if (gapped) idle($urandom_range(0, 2));
        end
        idle(3);
    endtask

    task automatic check_basic(input string tag);
        check_eq({tag, "_q0_empty"}, q0.size(), 32'd0);
        check_eq({tag, "_q1_empty"}, q1.size(), 32'd0);
        check_eq({tag, "_n0"}, cap0.size(), 32'd16);
        check_eq({tag, "_n1"}, cap1.size(), 32'd16);
        if (cap0.size() == 16 && cap1.size() == 16) begin
            for (int i = 0; i < D; i++) begin
                check_eq({tag, "_sum_s0"}, {16'd0, cap0[i]}, 32'(10 + 2*i));
                check_eq({tag, "_sum_s1"}, {16'd0, cap1[i]}, 32'(5 + i));
                check_eq({tag, "_dif_s0"}, {16'd0, cap0[i+D]}, 32'h0000_FFF8);
                check_eq({tag, "_dif_s1"}, {16'd0, cap1[i+D]}, 32'h0000_FFFC);
            end
        end
    endtask

    initial begin
        idle(2);
        do_reset();

        basic_stream(1'b0);
        check_basic("basic");

        do_reset();
        basic_stream(1'b1);
        check_basic("gapped");

        // Mid-frame reset, then a clean stream.
        do_reset();
        for (int i = 1; i <= 5; i++) drive(1'b1, W'(i * 3), W'(i));
        do_reset();
        basic_stream(1'b0);
        check_basic("midrst");

        // Extremes: a = 7FFF/8000 against b = 7FFF.
        do_reset();
        for (int i = 0; i < D; i++) drive(1'b1, (i < D/2) ? 16'h7FFF : 16'h8000, 16'h7FFF);
        for (int i = 0; i < D; i++) drive(1'b1, 16'h7FFF, 16'h8000);
        for (int i = 0; i < D; i++) drive(1'b1, '0, '0);
        idle(3);
        check_eq("ext_n", cap1.size() + cap0.size(), 32'd32);
        if (cap0.size() == 16 && cap1.size() == 16) begin
            check_eq("ext_sum_s1", {16'd0, cap1[0]}, 32'h0000_7FFF);
            check_eq("ext_dif0_s1", {16'd0, cap1[D]}, 32'h0000_0000);
            check_eq("ext_dif8000_s1", {16'd0, cap1[D + D/2]}, 32'h0000_8000);
            check_eq("ext_sum_s0", {16'd0, cap0[0]}, 32'h0000_FFFE);
        end

        // Back-to-back random frames.
        do_reset();
        n_out0 = 0;
        n_out1 = 0;
        for (int i = 0; i < 4*2*D; i++) drive(1'b1, W'($urandom), W'($urandom));
        for (int i = 0; i < D; i++) drive(1'b1, W'($urandom), W'($urandom));
        idle(3);
        check_eq("b2b_n0", n_out0, 32'd64);
        check_eq("b2b_n1", n_out1, 32'd64);
        check_eq("b2b_q_empty", q0.size() + q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdf_butterfly.md
Name: sdf_butterfly

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT. It sits directly upstream of a DelayBuffer instance and forms a feedback loop with it.
- First half of each 2*DELAY-sample frame: input samples are parked in the buffer, and the previous frame's differences are drained out.
- Second half: each incoming sample is combined with the sample parked DELAY beats earlier. The sum is emitted immediately; the difference is written back into the buffer.

Parameters:
- WIDTH, 16, bits per real/imag component, two's complement.
- DELAY, 8, butterfly span in samples (= depth of the attached DelayBuffer); power of two, >= 2.
- ADDR_WIDTH, 3, log2(DELAY).
- SCALE, 1, 1 = butterfly results arithmetic-shifted right by 1; 0 = results wrap to WIDTH bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_en  in  1  input sample valid; one sample per asserted cycle
- in_re  in  WIDTH  input real part
- in_im  in  WIDTH  input imag part
- db_wr_en  out  1  write/advance strobe to DelayBuffer in_en; combinational, equals in_en
- db_wr_data  out  2*WIDTH  {re,im} written to DelayBuffer in_data; combinational
- db_rd_data  in  2*WIDTH  {re,im} from DelayBuffer out_data
- out_en  out  1  output sample valid (registered)
- out_re  out  WIDTH  output real part (registered)
- out_im  out  WIDTH  output imag part (registered)

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high, sampled on rising clock.
- Reset values: cnt=0, primed=0, out_en=0, out_re=0, out_im=0.
- Buffer contract: on a cycle with in_en=1, db_rd_data equals the db_wr_data written DELAY in_en-beats earlier. The buffer advances only on db_wr_en.
- Beat counter cnt (ADDR_WIDTH+1 bits):
  - Increments on in_en and wraps 2*DELAY-1 -> 0.
  - Holds when in_en=0; gaps are allowed anywhere.
  - bf = cnt[ADDR_WIDTH].
- Phase bf=0 (fill/drain), on each in_en beat:
  - db_wr_data = {in_re,in_im}.
  - Output candidate = db_rd_data, which holds a difference from the previous frame.
  - out_en next cycle = primed.
- Phase bf=1 (butterfly), on each in_en beat, with a = db_rd_data and b = {in_re,in_im}:
  - sum = a+b and diff = a-b, per component, computed at WIDTH+1 bits.
  - SCALE=1: result = (WIDTH+1-bit value) >>> 1, truncated toward -inf.
  - SCALE=0: result = low WIDTH bits.
  - db_wr_data = diff.
  - Output candidate = sum; out_en next cycle = 1.
- primed:
  - Set on the in_en beat where cnt = 2*DELAY-1 (last butterfly beat).
  - Stays set until reset.
- Output register:
  - On in_en: out_en, out_re and out_im load as above, one cycle after the accepted beat.
  - When in_en=0: out_en <= 0 and out_re/out_im hold their value.
- Latency:
  - Sum of pair (n, n+DELAY) appears 1 cycle after sample n+DELAY is accepted.
  - The diff of that pair appears 1 cycle after sample n+2*DELAY is accepted.
- Output order per frame: DELAY sums, then DELAY diffs of the same frame emitted during the next frame's fill phase.
- Flush: the last frame's diffs are emitted only when further in_en beats arrive. The upstream supplies DELAY flush beats of any value; those beats prime a new frame.
- Reset mid-frame: cnt and primed clear. Stale buffer contents are never emitted, because primed=0 gates the first fill phase. The buffer shares this reset.
- Overflow: SCALE=1 never overflows. SCALE=0 wraps silently; no saturation or flag.

Test Plan:
- Basic sums/diffs:
  - Stimulus: SCALE=0, DELAY=8; contiguous in_re = 1..16, in_im = 0, followed by 8 flush beats of 0.
  - Beats 1-8: out_en=0.
  - Beats 9-16: out_re = 10,12,...,24, each 1 cycle after its beat.
  - Flush beats: out_re = 0xFFF8 (-8) x8; out_im = 0 throughout.
- Scaling:
  - Stimulus: SCALE=1, same stream.
  - Sums: 5,6,...,12.
  - Diffs: 0xFFFC (-4) x8.
- Extremes with SCALE=1:
  - Pair a=0x7FFF, b=0x7FFF -> sum 0x7FFF, diff 0x0000.
  - Pair a=0x8000, b=0x7FFF -> diff 0x8000.
  - Same pair with SCALE=0: a=0x7FFF, b=0x7FFF -> sum 0xFFFE.
- Gapped input:
  - Stimulus: the basic stream with in_en toggling 1,0,0,1 randomly.
  - Identical value sequence to the basic test.
  - out_en never asserts in a cycle not following an accepted beat.
  - cnt holds across gaps.
- Reset mid-frame:
  - Stimulus: 5 beats, then reset for 1 cycle, then the basic stream.
  - Output is identical to the clean run; out_en=0 for the first 8 beats after reset.
- Back-to-back frames:
  - Stimulus: 4 contiguous frames of random data.
  - Output matches a reference model sample for sample.
  - Exactly 8 valid outputs per 8 beats after the first frame.
